alu_control_sequencer: RTL and testbench
========================================

Name: alu_control_sequencer

Overview:
- Hardware control unit that drives the datapath's strobe inputs (PCout, Zlowout, MDRout, MDRin, Read, Yin, register in/out selects, ALU op) through the fetch / execute step sequence T0–T5 for 3-register ALU instructions.
- It is the initiator side of the datapath control interface and replaces hand-sequenced stimulus.
- It reads the instruction from the datapath IR and waits on a memory-ready handshake during fetch.

Parameters:
- OPC_W, 5, opcode field width: ir[31:27].
- REG_W, 4, register field width: ra = ir[26:23], rb = ir[22:19], rc = ir[18:15].
- MEM_TIMEOUT, 8, maximum T1 wait cycles before bus error; legal range 1..255.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- clear  in  1  synchronous active-high reset.
- ir  in  32  instruction register contents from the datapath.
- mem_ready  in  1  memory read data valid on Mdatain this cycle.
- PCout, Zlowout, MDRout  out  1  bus drive strobes.
- MARin, PCin, IncPC, Read, MDRin, IRin, Yin, Zin  out  1  load strobes.
- reg_in  out  16  one-hot general-register load enables (bit n = Rn in).
- reg_out  out  16  one-hot general-register bus drive (bit n = Rn out).
- alu_op  out  OPC_W  ALU function select; 0 when no ALU operation is active.
- run  out  1  high unless halted.
- illegal_op  out  1  one-cycle pulse on an undefined opcode.
- bus_err  out  1  one-cycle pulse on memory timeout.

Behaviour:
- Reset: clock and clear are the single clock and reset; reset is synchronous and active-high. While clear is high the state is IDLE, all strobes are 0, reg_in and reg_out are 0, alu_op is 0, run is 1, and the pulse outputs are 0. A clear asserted mid-instruction aborts it at the next edge, with no partial register write.
- Outputs are Moore functions of the registered state plus the registered ir fields. Each output is valid for the whole state cycle, and at most one bus driver is high in any cycle.
- State sequence, one state per cycle unless noted:
  - IDLE -> T0 unconditionally.
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin. Stays in T1 until mem_ready = 1. A wait counter increments each cycle mem_ready = 0. When the counter reaches MEM_TIMEOUT, bus_err pulses and the state goes to HALT.
  - T2: MDRout, IRin.
  - T3: reg_out[rb], Yin.
  - T4: reg_out[rc], Zin, alu_op = ir[31:27].
  - T5: Zlowout, reg_in[ra]. Then back to T0.
- Decode in T3, using ir as loaded in T2:
  - Legal ALU opcodes: 00011 add, 00100 sub, 00101 and, 00110 or, 00111 shr, 01000 shl, 01001 ror, 01010 rol.
  - 11010 nop: T3 -> T0 directly, no strobes in T3.
  - 11011 halt: T3 -> HALT.
  - Any other opcode: illegal_op pulses in T3, then T0. No register write occurs.
- HALT: all strobes 0, run = 0. Only clear exits HALT.
- ra = rb = rc is legal; the selects simply coincide.
- The wait counter is 8 bits, reset on entry to T1, and saturates at MEM_TIMEOUT.
- mem_ready is ignored outside T1.

Decomposition:
- Package ctrl_pkg: opcode constants, state enum (IDLE, T0–T5, HALT), field bit positions.
- Sub-module reg_select_decoder: 4-to-16 one-hot decoder with an enable. Instantiated twice: for reg_in and reg_out.

Test Plan:
- Program ir = 32'h28918000 (and R1,R2,R3) with mem_ready high in T1 -> the following, then T0:
  - T1 lasts 1 cycle.
  - T3: reg_out = 16'h0004, Yin = 1.
  - T4: reg_out = 16'h0008, alu_op = 5'b00101, Zin = 1.
  - T5: reg_in = 16'h0002, Zlowout = 1.
- Same instruction with mem_ready delayed 3 cycles -> T1 held 4 cycles with Read and MDRin high throughout. The rest of the sequence is unchanged.
- mem_ready held low with MEM_TIMEOUT = 8 -> bus_err pulses once after 8 T1 cycles, then run = 0 and all strobes stay 0 until clear.
- ir opcode 11011 -> HALT after T3, run = 0. Opcode 11111 -> illegal_op pulse in T3 with no reg_in activity, then T0.
- clear asserted during T4 -> next cycle IDLE, all outputs 0, no reg_in pulse. Cycle after: T0 with PCout = 1.
- nop 11010 -> T0–T3 take 4 cycles, then T0. reg_in, Yin and Zin stay 0 in T3.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the ALU instruction control sequencer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package ctrl_pkg;

   // Default instruction field widths and bit positions inside the 32-bit IR
   localparam int OPC_WIDTH = 5;
   localparam int REG_WIDTH = 4;
   localparam int OPC_LSB   = 27;   // ir[31:27]
   localparam int RA_LSB    = 23;   // ir[26:23]
   localparam int RB_LSB    = 19;   // ir[22:19]
   localparam int RC_LSB    = 15;   // ir[18:15]

   // Opcodes
   localparam logic [OPC_WIDTH-1:0] OP_ADD  = 5'b00011;
   localparam logic [OPC_WIDTH-1:0] OP_SUB  = 5'b00100;
   localparam logic [OPC_WIDTH-1:0] OP_AND  = 5'b00101;
   localparam logic [OPC_WIDTH-1:0] OP_OR   = 5'b00110;
   localparam logic [OPC_WIDTH-1:0] OP_SHR  = 5'b00111;
   localparam logic [OPC_WIDTH-1:0] OP_SHL  = 5'b01000;
   localparam logic [OPC_WIDTH-1:0] OP_ROR  = 5'b01001;
   localparam logic [OPC_WIDTH-1:0] OP_ROL  = 5'b01010;
   localparam logic [OPC_WIDTH-1:0] OP_NOP  = 5'b11010;
   localparam logic [OPC_WIDTH-1:0] OP_HALT = 5'b11011;

   typedef enum logic [2:0] {
      ST_IDLE, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_HALT
   } state_e;

   typedef enum logic [1:0] {
      CLS_ALU, CLS_NOP, CLS_HALT, CLS_ILLEGAL
   } op_class_e;

   // Single-bit datapath strobes, grouped so they register as one word
   typedef struct packed {
      logic pc_out;
      logic zlow_out;
      logic mdr_out;
      logic mar_in;
      logic pc_in;
      logic inc_pc;
      logic read;
      logic mdr_in;
      logic ir_in;
      logic y_in;
      logic z_in;
   } strobe_t;

   function automatic op_class_e classify(input logic [OPC_WIDTH-1:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR,
         OP_SHR, OP_SHL, OP_ROR, OP_ROL: return CLS_ALU;
         OP_NOP:                         return CLS_NOP;
         OP_HALT:                        return CLS_HALT;
         default:                        return CLS_ILLEGAL;
      endcase
   endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// One-hot general-register select: bit sel is set when en is high.
// Latency: combinational.
// Backpressure: none.
module reg_select_decoder #(
   parameter int SEL_W = 4
) (
   input  logic                    en,
   input  logic [SEL_W-1:0]        sel,
   output logic [(1<<SEL_W)-1:0]   onehot
);

   // Drive exactly one enable when active, none otherwise
   always_comb begin
      onehot = '0;
      if (en) onehot[sel] = 1'b1;
   end

endmodule

// File: rtl/alu_control_sequencer.sv
// Steps the datapath strobes through fetch (T0-T2) and execute (T3-T5) for 3-register ALU ops.
// Latency: outputs registered; every strobe is valid for the whole state cycle it belongs to.
// Backpressure: holds in T1 until mem_ready, giving up with bus_err after MEM_TIMEOUT idle cycles.
module alu_control_sequencer
   import ctrl_pkg::*;
#(
   parameter int OPC_W       = OPC_WIDTH,
   parameter int REG_W       = REG_WIDTH,
   parameter int MEM_TIMEOUT = 8
) (
   input  logic                    clock,
   input  logic                    clear,
   input  logic [31:0]             ir,
   input  logic                    mem_ready,
   output logic                    PCout,
   output logic                    Zlowout,
   output logic                    MDRout,
   output logic                    MARin,
   output logic                    PCin,
   output logic                    IncPC,
   output logic                    Read,
   output logic                    MDRin,
   output logic                    IRin,
   output logic                    Yin,
   output logic                    Zin,
   output logic [(1<<REG_W)-1:0]   reg_in,
   output logic [(1<<REG_W)-1:0]   reg_out,
   output logic [OPC_W-1:0]        alu_op,
   output logic                    run,
   output logic                    illegal_op,
   output logic                    bus_err
);

   state_e               state, nxt;
   logic [7:0]           wait_cnt;
   logic [OPC_W-1:0]     op_q;
   logic [REG_W-1:0]     ra_q, rb_q, rc_q;
   logic [OPC_W-1:0]     op_in;
   logic [REG_W-1:0]     rb_in;
   logic                 unused_ir;
   op_class_e            cls;

   strobe_t              stb_q, n_stb;
   logic                 rin_en_q, rout_en_q, n_rin_en, n_rout_en;
   logic [REG_W-1:0]     rin_sel_q, rout_sel_q, n_rin_sel, n_rout_sel;
   logic [OPC_W-1:0]     alu_op_q, n_alu_op;
   logic                 run_q, illegal_q, bus_err_q, n_run, n_illegal, n_bus_err;

   assign op_in     = ir[OPC_LSB +: OPC_W];
   assign rb_in     = ir[RB_LSB +: REG_W];
   assign unused_ir = ^ir[RC_LSB-1:0];

   // The opcode that matters is the one arriving from the IR while leaving T2,
   // and the captured copy from then on.
   assign cls = classify((state == ST_T2) ? op_in : op_q);

   // Next state plus the strobe pattern of the state being entered
   always_comb begin
      nxt        = state;
      n_stb      = '0;
      n_rin_en   = 1'b0;
      n_rin_sel  = ra_q;
      n_rout_en  = 1'b0;
      n_rout_sel = rc_q;
      n_alu_op   = '0;
      n_run      = 1'b1;
      n_illegal  = 1'b0;
      n_bus_err  = 1'b0;

      case (state)
         ST_IDLE: nxt = ST_T0;
         ST_T0:   nxt = ST_T1;
         ST_T1: begin
            if (mem_ready) begin
               nxt = ST_T2;
            end else if (wait_cnt == 8'(MEM_TIMEOUT - 1)) begin
               nxt       = ST_HALT;
               n_bus_err = 1'b1;
            end
         end
         ST_T2:   nxt = ST_T3;
         ST_T3: begin
            case (cls)
               CLS_ALU:  nxt = ST_T4;
               CLS_HALT: nxt = ST_HALT;
               default:  nxt = ST_T0;
            endcase
         end
         ST_T4:   nxt = ST_T5;
         ST_T5:   nxt = ST_T0;
         ST_HALT: nxt = ST_HALT;
         default: nxt = ST_IDLE;
      endcase

      case (nxt)
         ST_T0: begin
            n_stb.pc_out = 1'b1;
            n_stb.mar_in = 1'b1;
            n_stb.inc_pc = 1'b1;
            n_stb.z_in   = 1'b1;
         end
         ST_T1: begin
            n_stb.zlow_out = 1'b1;
            n_stb.pc_in    = 1'b1;
            n_stb.read     = 1'b1;
            n_stb.mdr_in   = 1'b1;
         end
         ST_T2: begin
            n_stb.mdr_out = 1'b1;
            n_stb.ir_in   = 1'b1;
         end
         ST_T3: begin
            // nop and halt leave T3 quiet; undefined opcodes only raise the flag
            if (cls == CLS_ALU) begin
               n_rout_en  = 1'b1;
               n_rout_sel = rb_in;
               n_stb.y_in = 1'b1;
            end else if (cls == CLS_ILLEGAL) begin
               n_illegal = 1'b1;
            end
         end
         ST_T4: begin
            n_rout_en  = 1'b1;
            n_rout_sel = rc_q;
            n_stb.z_in = 1'b1;
            n_alu_op   = op_q;
         end
         ST_T5: begin
            n_stb.zlow_out = 1'b1;
            n_rin_en       = 1'b1;
            n_rin_sel      = ra_q;
         end
         ST_HALT: n_run = 1'b0;
         default: ;
      endcase
   end

   // State, captured IR fields, T1 wait counter and registered outputs
   always_ff @(posedge clock) begin
      if (clear) begin
         state      <= ST_IDLE;
         wait_cnt   <= '0;
         op_q       <= '0;
         ra_q       <= '0;
         rb_q       <= '0;
         rc_q       <= '0;
         stb_q      <= '0;
         rin_en_q   <= 1'b0;
         rin_sel_q  <= '0;
         rout_en_q  <= 1'b0;
         rout_sel_q <= '0;
         alu_op_q   <= '0;
         run_q      <= 1'b1;
         illegal_q  <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         state      <= nxt;
         stb_q      <= n_stb;
         rin_en_q   <= n_rin_en;
         rin_sel_q  <= n_rin_sel;
         rout_en_q  <= n_rout_en;
         rout_sel_q <= n_rout_sel;
         alu_op_q   <= n_alu_op;
         run_q      <= n_run;
         illegal_q  <= n_illegal;
         bus_err_q  <= n_bus_err;
         if (state == ST_T2) begin
            op_q <= op_in;
            ra_q <= ir[RA_LSB +: REG_W];
            rb_q <= rb_in;
            rc_q <= ir[RC_LSB +: REG_W];
         end
         if (state == ST_T0) begin
            wait_cnt <= '0;
         end else if (state == ST_T1 && !mem_ready && wait_cnt != 8'(MEM_TIMEOUT)) begin
            wait_cnt <= wait_cnt + 8'd1;
         end
      end
   end

   reg_select_decoder #(.SEL_W(REG_W)) u_in_dec (
      .en     (rin_en_q),
      .sel    (rin_sel_q),
      .onehot (reg_in)
   );

   reg_select_decoder #(.SEL_W(REG_W)) u_out_dec (
      .en     (rout_en_q),
      .sel    (rout_sel_q),
      .onehot (reg_out)
   );

   assign PCout      = stb_q.pc_out;
   assign Zlowout    = stb_q.zlow_out;
   assign MDRout     = stb_q.mdr_out;
   assign MARin      = stb_q.mar_in;
   assign PCin       = stb_q.pc_in;
   assign IncPC      = stb_q.inc_pc;
   assign Read       = stb_q.read;
   assign MDRin      = stb_q.mdr_in;
   assign IRin       = stb_q.ir_in;
   assign Yin        = stb_q.y_in;
   assign Zin        = stb_q.z_in;
   assign alu_op     = alu_op_q;
   assign run        = run_q;
   assign illegal_op = illegal_q;
   assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Randomized bench: a step-level reference model queues the expected output word for every cycle.
// Latency: a monitor on the falling edge pops one expectation per cycle and compares.
// Backpressure: mem_ready is driven by the bench to exercise T1 waits and timeouts.
module tb_alu_control_sequencer;

   localparam int MEM_TIMEOUT = 8;

   logic        clock, clear, mem_ready;
   logic [31:0] ir;
   logic        PCout, Zlowout, MDRout, MARin, PCin, IncPC, Read, MDRin, IRin, Yin, Zin;
   logic [15:0] reg_in, reg_out;
   logic [4:0]  alu_op;
   logic        run, illegal_op, bus_err;

   typedef struct packed {
      logic pc_out, zlow_out, mdr_out, mar_in, pc_in, inc_pc, read, mdr_in, ir_in, y_in, z_in;
      logic [15:0] reg_in;
      logic [15:0] reg_out;
      logic [4:0]  alu_op;
      logic run, illegal_op, bus_err;
   } obs_t;

   obs_t  exp_q[$];
   string tag_q[$];
   int    vectors = 0;
   int    miscompares = 0;

   alu_control_sequencer #(.OPC_W(5), .REG_W(4), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
      .clock(clock), .clear(clear), .ir(ir), .mem_ready(mem_ready),
      .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .MARin(MARin), .PCin(PCin),
      .IncPC(IncPC), .Read(Read), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
      .reg_in(reg_in), .reg_out(reg_out), .alu_op(alu_op), .run(run),
      .illegal_op(illegal_op), .bus_err(bus_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic obs_t sample();
      obs_t a;
      a.pc_out = PCout;   a.zlow_out = Zlowout; a.mdr_out = MDRout; a.mar_in = MARin;
      a.pc_in = PCin;     a.inc_pc = IncPC;     a.read = Read;      a.mdr_in = MDRin;
      a.ir_in = IRin;     a.y_in = Yin;         a.z_in = Zin;
      a.reg_in = reg_in;  a.reg_out = reg_out;  a.alu_op = alu_op;
      a.run = run;        a.illegal_op = illegal_op; a.bus_err = bus_err;
      return a;
   endfunction

   // Quiet word: nothing driven, machine running
   function automatic obs_t idle_v();
      obs_t e = '0;
      e.run = 1'b1;
      return e;
   endfunction

   function automatic obs_t halt_v();
      obs_t e = '0;
      return e;
   endfunction

   function automatic bit is_alu(input logic [4:0] op);
      return op inside {5'b00011, 5'b00100, 5'b00101, 5'b00110,
                        5'b00111, 5'b01000, 5'b01001, 5'b01010};
   endfunction

   // Monitor: one expectation consumed per cycle, away from the active edge
   always @(negedge clock) begin
      if (exp_q.size() > 0) begin
         obs_t  e;
         obs_t  a;
         string t;
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         a = sample();
         vectors++;
         if (a !== e) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h want %h", t, $time, a, e);
         end
      end
   end

   // Record what the outputs must show during the current cycle, then advance one cycle
   task automatic cyc(input obs_t e, input string tag);
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(posedge clock);
      #1;
   endtask

   // One instruction from T0; delay = T1 cycles with mem_ready low before it goes high
   task automatic run_instr(input logic [31:0] instr, input int delay, input bit abort_t4,
                            output bit halted);
      obs_t       e;
      bit         got;
      logic [4:0] op;
      logic [3:0] ra, rb, rc;
      op = instr[31:27];
      ra = instr[26:23];
      rb = instr[22:19];
      rc = instr[18:15];
      halted = 1'b0;
      got    = 1'b0;
      ir     = instr;

      e = idle_v(); e.pc_out = 1; e.mar_in = 1; e.inc_pc = 1; e.z_in = 1;
      mem_ready = 1'($urandom_range(0, 1));
      cyc(e, "T0");

      for (int i = 0; i < MEM_TIMEOUT; i++) begin
         mem_ready = (i >= delay);
         e = idle_v(); e.zlow_out = 1; e.pc_in = 1; e.read = 1; e.mdr_in = 1;
         cyc(e, "T1");
         if (i >= delay) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         e = halt_v(); e.bus_err = 1;
         mem_ready = 1'($urandom_range(0, 1));
         cyc(e, "bus_err");
         halted = 1'b1;
         return;
      end

      e = idle_v(); e.mdr_out = 1; e.ir_in = 1;
      mem_ready = 1'($urandom_range(0, 1));
      cyc(e, "T2");

      e = idle_v();
      if (is_alu(op)) begin
         e.reg_out = 16'h1 << rb;
         e.y_in    = 1;
      end else if (op != 5'b11010 && op != 5'b11011) begin
         e.illegal_op = 1;
      end
      cyc(e, "T3");
      if (op == 5'b11011) begin
         halted = 1'b1;
         return;
      end
      if (!is_alu(op)) return;

      e = idle_v(); e.reg_out = 16'h1 << rc; e.z_in = 1; e.alu_op = op;
      if (abort_t4) clear = 1'b1;
      cyc(e, "T4");
      if (abort_t4) begin
         clear = 1'b0;
         cyc(idle_v(), "abort_idle");
         return;
      end

      e = idle_v(); e.zlow_out = 1; e.reg_in = 16'h1 << ra;
      cyc(e, "T5");
   endtask

   // Sit in HALT for a while, then clear back to IDLE
   task automatic recover();
      repeat (3) begin
         mem_ready = 1'($urandom_range(0, 1));
         cyc(halt_v(), "HALT");
      end
      clear = 1'b1;
      cyc(halt_v(), "HALT_clr");
      clear = 1'b0;
      cyc(idle_v(), "post_clear_idle");
   endtask

   function automatic logic [31:0] rand_alu();
      logic [4:0] ops [8];
      ops = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001, 5'b01010};
      return {ops[$urandom_range(0, 7)], 27'($urandom)};
   endfunction

   initial begin
      bit h;
      clear = 1'b1; ir = '0; mem_ready = 1'b0;
      @(posedge clock);
      #1;
      cyc(idle_v(), "reset_hold");
      clear = 1'b0;
      cyc(idle_v(), "reset_idle");

      run_instr(32'h28918000, 0, 1'b0, h);                        // and R1,R2,R3
      run_instr(32'h28918000, 3, 1'b0, h);                        // T1 held 4 cycles
      run_instr({5'b11010, 27'($urandom)}, 0, 1'b0, h);           // nop
      run_instr({5'b11111, 27'($urandom)}, 1, 1'b0, h);           // illegal
      run_instr({5'b00011, 4'd7, 4'd7, 4'd7, 15'($urandom)}, 0, 1'b0, h);
      run_instr({5'b01010, 4'd15, 4'd0, 4'd15, 15'd0}, MEM_TIMEOUT - 1, 1'b0, h);
      run_instr(rand_alu(), 2, 1'b1, h);                          // clear during T4

      for (int n = 0; n < 30; n++) begin
         logic [31:0] instr;
         if (n % 3 == 2) instr = $urandom;
         else            instr = rand_alu();
         run_instr(instr, $urandom_range(0, 4), 1'b0, h);
         if (h) recover();
      end

      run_instr({5'b11011, 27'($urandom)}, 0, 1'b0, h);           // halt opcode
      if (h) recover();
      else begin
         miscompares++;
         $display("FAIL halt_model: got running want halted");
      end
      run_instr(32'h28918000, MEM_TIMEOUT + 5, 1'b0, h);          // memory never ready
      if (h) recover();
      run_instr(32'h28918000, 0, 1'b0, h);

      @(negedge clock);
      #1;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
